zbt_vga_arbiter: RTL and testbench

- Sits between the ZBT SRAM port and the VGA output stage; the write requester (NTSC capture) is its only other client.
- Services the VGA read strobe: converts the latched pixel coordinate into a double-buffered frame address, issues a pipelined ZBT read and returns one 36-bit word (two 18-bit YCrCb pixels) with a done pulse.
- Fills idle memory cycles with queued writes into the back buffer.
- Swaps front/back buffers on the frame flag.

---
 rtl/zbt_vga_arbiter_pkg.sv | 24 ++
 rtl/delay.sv | 25 ++
 rtl/zbt_vga_arbiter_vga_addr_calc.sv | 29 ++
 rtl/zbt_vga_arbiter.sv | 139 +++++++++++++
 tb/tb_zbt_vga_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/zbt_vga_arbiter_pkg.sv
// Shared widths, frame geometry and payload types for the ZBT/VGA arbiter.
package zbt_vga_arbiter_pkg;

  localparam int unsigned LOG_MEM        = 36;
  localparam int unsigned LOG_ADDR       = 19;
  localparam int unsigned VGA_HPIX       = 640;
  localparam int unsigned VGA_VPIX       = 480;
  localparam int unsigned ZBT_LAT        = 2;
  localparam int unsigned WORDS_PER_LINE = 320;
  localparam int unsigned COORD_W        = 10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2
  } arb_e;

  // Tag carried alongside an issued read until its data returns.
  typedef struct packed {
    logic valid;
    logic oor;
  } rd_tag_t;

endpackage

// File: rtl/delay.sv
// Fixed-depth register delay line with asynchronous active-low clear.
module delay #(
  parameter int unsigned W = 1,
  parameter int unsigned N = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [N];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < N; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[N-1];

endmodule

// File: rtl/zbt_vga_arbiter_vga_addr_calc.sv
// Pixel coordinate to frame-buffer word address; the issue-edge register of
// mem_addr in the arbiter completes this stage.
module vga_addr_calc
  import zbt_vga_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = LOG_ADDR,
  parameter int unsigned HPIX   = VGA_HPIX,
  parameter int unsigned VPIX   = VGA_VPIX
) (
  input  logic               bank_i,
  input  logic [COORD_W-1:0] hcount_i,
  input  logic [COORD_W-1:0] vcount_i,
  output logic [ADDR_W-1:0]  addr_c_o,
  output logic               in_range_c_o
);

  localparam int unsigned OFF_W = ADDR_W - 1;

  logic [OFF_W-1:0] vc_ext;
  logic [OFF_W-1:0] off_c;

  // Two pixels per word, so a line is 320 words: v*256 + v*64 + h/2.
  assign vc_ext = OFF_W'(vcount_i);
  assign off_c  = (vc_ext << 8) + (vc_ext << 6) + OFF_W'(hcount_i[COORD_W-1:1]);

  assign addr_c_o     = {bank_i, off_c};
  assign in_range_c_o = (hcount_i < COORD_W'(HPIX)) && (vcount_i < COORD_W'(VPIX));

endmodule

// File: rtl/zbt_vga_arbiter.sv
// ZBT SRAM arbiter: VGA reads from the display bank take priority, capture
// writes fill idle cycles into the back bank, banks swap on frame_flag.
module zbt_vga_arbiter
  import zbt_vga_arbiter_pkg::*;
#(
  parameter int unsigned LOG_MEM  = zbt_vga_arbiter_pkg::LOG_MEM,
  parameter int unsigned LOG_ADDR = zbt_vga_arbiter_pkg::LOG_ADDR,
  parameter int unsigned HPIX     = VGA_HPIX,
  parameter int unsigned VPIX     = VGA_VPIX,
  parameter int unsigned ZBT_LAT  = zbt_vga_arbiter_pkg::ZBT_LAT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                frame_flag,
  input  logic                vga_flag,
  input  logic [9:0]          clocked_hcount,
  input  logic [9:0]          clocked_vcount,
  output logic [LOG_MEM-1:0]  vga_pixel,
  output logic                done_vga,
  input  logic                wr_req,
  input  logic [LOG_ADDR-2:0] wr_addr,
  input  logic [LOG_MEM-1:0]  wr_data,
  output logic                wr_ack,
  output logic [LOG_ADDR-1:0] mem_addr,
  output logic                mem_we,
  output logic [LOG_MEM-1:0]  mem_write_data,
  input  logic [LOG_MEM-1:0]  mem_read_data
);

  logic                bank_q, bank_d;
  logic [LOG_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic                wr_ack_q, wr_ack_d;
  logic [LOG_MEM-1:0]  wdata_q, wdata_d;
  rd_tag_t             tag_q, tag_d;
  rd_tag_t             tag_ret;
  logic [LOG_MEM-1:0]  pixel_q, pixel_d;
  logic                done_q, done_d;

  logic [LOG_ADDR-1:0] rd_addr_c;
  logic                rd_in_range_c;
  arb_e                arb_c;

  vga_addr_calc #(
    .ADDR_W (LOG_ADDR),
    .HPIX   (HPIX),
    .VPIX   (VPIX)
  ) u_addr_calc (
    .bank_i       (bank_q),
    .hcount_i     (clocked_hcount),
    .vcount_i     (clocked_vcount),
    .addr_c_o     (rd_addr_c),
    .in_range_c_o (rd_in_range_c)
  );

  // Read tags and write data both ride ZBT_LAT further stages behind issue.
  delay #(.W($bits(rd_tag_t)), .N(ZBT_LAT)) u_rd_pipe (
    .clock (clock),
    .reset (reset),
    .d_i   (tag_q),
    .q_o   (tag_ret)
  );

  delay #(.W(LOG_MEM), .N(ZBT_LAT)) u_wd_pipe (
    .clock (clock),
    .reset (reset),
    .d_i   (wdata_q),
    .q_o   (mem_write_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      wdata_q    <= '0;
      tag_q      <= '0;
      pixel_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      wr_ack_q   <= wr_ack_d;
      wdata_q    <= wdata_d;
      tag_q      <= tag_d;
      pixel_q    <= pixel_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    arb_c      = ARB_IDLE;
    bank_d     = bank_q ^ frame_flag;
    mem_addr_d = mem_addr_q;
    mem_we_d   = 1'b0;
    wr_ack_d   = 1'b0;
    wdata_d    = wdata_q;
    tag_d      = '0;
    pixel_d    = pixel_q;
    done_d     = 1'b0;

    // An out-of-range strobe still returns a done but leaves the bus free.
    if (vga_flag && rd_in_range_c) begin
      arb_c = ARB_READ;
    end else if (wr_req && !wr_ack_q) begin
      arb_c = ARB_WRITE;
    end

    tag_d.valid = vga_flag;
    tag_d.oor   = vga_flag & ~rd_in_range_c;

    case (arb_c)
      ARB_READ: begin
        mem_addr_d = rd_addr_c;
      end
      ARB_WRITE: begin
        mem_addr_d = {~bank_q, wr_addr};
        mem_we_d   = 1'b1;
        wr_ack_d   = 1'b1;
        wdata_d    = wr_data;
      end
      default: ;
    endcase

    if (tag_ret.valid) begin
      done_d  = 1'b1;
      pixel_d = tag_ret.oor ? '0 : mem_read_data;
    end
  end

  assign vga_pixel = pixel_q;
  assign done_vga  = done_q;
  assign wr_ack    = wr_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_zbt_vga_arbiter.sv
// Randomized bench for zbt_vga_arbiter against a transaction-level model of
// bank selection, arbitration and return timing.
module tb_zbt_vga_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_flag, vga_flag;
  logic [9:0]  clocked_hcount, clocked_vcount;
  logic [35:0] vga_pixel;
  logic        done_vga;
  logic        wr_req;
  logic [17:0] wr_addr;
  logic [35:0] wr_data;
  logic        wr_ack;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [35:0] mem_write_data;
  logic [35:0] mem_read_data;

  always #5 clock = ~clock;

  zbt_vga_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .frame_flag     (frame_flag),
    .vga_flag       (vga_flag),
    .clocked_hcount (clocked_hcount),
    .clocked_vcount (clocked_vcount),
    .vga_pixel      (vga_pixel),
    .done_vga       (done_vga),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ack         (wr_ack),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  typedef struct {
    int          due;
    logic [35:0] v;
  } ev_t;

  int          checks = 0;
  int          errors = 0;
  int          n = 0;
  logic        m_bank = 1'b0;
  logic        m_ack = 1'b0;
  logic [18:0] m_addr = '0;
  logic [35:0] last_pix = '0;
  ev_t         done_q[$];
  ev_t         wd_q[$];

  function automatic logic [35:0] mem_fn(input logic [18:0] a);
    if (a == 19'h00282) return 36'hA5A5A5A5A;
    return {~a[16:0], a};
  endfunction

  function automatic logic [18:0] frame_addr(input logic b, input logic [9:0] h, input logic [9:0] v);
    int off;
    off = int'(v) * 320 + int'(h) / 2;
    return {b, 18'(off)};
  endfunction

  // ZBT model: address sampled one edge after issue, data out the edge after.
  logic [18:0] zbt_a1;
  always @(posedge clock) begin
    zbt_a1        <= mem_addr;
    mem_read_data <= mem_fn(zbt_a1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix"},   64'(vga_pixel), 64'(0));
    chk({tag, "_done"},  64'(done_vga), 64'(0));
    chk({tag, "_ack"},   64'(wr_ack), 64'(0));
    chk({tag, "_addr"},  64'(mem_addr), 64'(0));
    chk({tag, "_we"},    64'(mem_we), 64'(0));
    chk({tag, "_wdata"}, 64'(mem_write_data), 64'(0));
  endtask

  task automatic model_reset();
    done_q.delete();
    wd_q.delete();
    m_bank   = 1'b0;
    m_ack    = 1'b0;
    m_addr   = '0;
    last_pix = '0;
  endtask

  // One clock: drive inputs, predict the edge, then compare every output.
  task automatic step(input logic vf, input logic [9:0] h, input logic [9:0] v, input logic ff,
                      input logic wr, input logic [17:0] wa, input logic [35:0] wd);
    logic in_rng, exp_we, exp_done;
    ev_t  e;
    @(negedge clock);
    vga_flag = vf; clocked_hcount = h; clocked_vcount = v; frame_flag = ff;
    wr_req = wr; wr_addr = wa; wr_data = wd;
    in_rng = (h < 10'd640) && (v < 10'd480);
    exp_we = 1'b0;
    if (vf) begin
      e.due = n + 3;
      e.v   = in_rng ? mem_fn(frame_addr(m_bank, h, v)) : 36'd0;
      done_q.push_back(e);
    end
    if (vf && in_rng) begin
      m_addr = frame_addr(m_bank, h, v);
    end else if (wr && !m_ack) begin
      m_addr = {~m_bank, wa};
      exp_we = 1'b1;
      e.due  = n + 2;
      e.v    = wd;
      wd_q.push_back(e);
    end
    if (ff) m_bank = ~m_bank;
    m_ack = exp_we;
    @(posedge clock);
    #1;
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("mem_we", 64'(mem_we), 64'(exp_we));
    chk("wr_ack", 64'(wr_ack), 64'(exp_we));
    exp_done = (done_q.size() > 0) && (done_q[0].due == n);
    chk("done_vga", 64'(done_vga), 64'(exp_done));
    if (exp_done) begin
      e = done_q.pop_front();
      last_pix = e.v;
    end
    chk("vga_pixel", 64'(vga_pixel), 64'(last_pix));
    if ((wd_q.size() > 0) && (wd_q[0].due == n)) begin
      e = wd_q.pop_front();
      chk("mem_wdata", 64'(mem_write_data), 64'(e.v));
    end
    n++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 18'd0, 36'd0);
  endtask

  initial begin
    logic        rq;
    logic [17:0] ra;
    logic [35:0] rdat;
    logic        vf, ff;
    logic [9:0]  h, v;

    reset = 1'b0; frame_flag = 1'b0; vga_flag = 1'b0; clocked_hcount = '0;
    clocked_vcount = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clock);
    #1;
    chk_zero("por");
    @(negedge clock);
    reset = 1'b1;

    // Reset asserted with reads in flight and strobes still pulsing.
    step(1'b1, 10'd5, 10'd2, 1'b0, 1'b0, 18'd0, 36'd0);
    step(1'b1, 10'd7, 10'd3, 1'b0, 1'b0, 18'd0, 36'd0);
    @(negedge clock);
    reset = 1'b0;
    vga_flag = 1'b1;
    #1;
    chk_zero("rst_mid");
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      vga_flag = ~vga_flag;
      @(posedge clock);
      #1;
      chk_zero("rst_hold");
    end
    @(negedge clock);
    reset = 1'b1;
    vga_flag = 1'b0;
    idle(5);

    // Single in-range read from bank 0.
    step(1'b1, 10'd5, 10'd2, 1'b0, 1'b0, 18'd0, 36'd0);
    chk("tp_rd_addr", 64'(mem_addr), 64'(19'h00282));
    idle(3);
    chk("tp_rd_done", 64'(done_vga), 64'(1));
    chk("tp_rd_pix", 64'(vga_pixel), 64'(36'hA5A5A5A5A));

    // Out-of-range strobe frees the cycle for a pending write.
    step(1'b1, 10'd640, 10'd10, 1'b0, 1'b1, 18'h00055, 36'h123456789);
    chk("tp_oor_wr_addr", 64'(mem_addr), 64'(19'h40055));
    chk("tp_oor_wr_we", 64'(mem_we), 64'(1));
    idle(3);
    chk("tp_oor_done", 64'(done_vga), 64'(1));
    chk("tp_oor_pix", 64'(vga_pixel), 64'(0));

    // Read beats a simultaneous write; write follows on the next cycle.
    step(1'b1, 10'd33, 10'd7, 1'b0, 1'b1, 18'h00100, 36'hFEDCBA987);
    chk("tp_pri_we", 64'(mem_we), 64'(0));
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 18'h00100, 36'hFEDCBA987);
    chk("tp_pri_addr", 64'(mem_addr), 64'(19'h40100));
    chk("tp_pri_ack", 64'(wr_ack), 64'(1));
    idle(2);
    chk("tp_pri_wdata", 64'(mem_write_data), 64'(36'hFEDCBA987));

    // Bank swap retargets both reads and writes.
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 18'd0, 36'd0);
    step(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 18'd0, 36'd0);
    chk("tp_swap_rd", 64'(mem_addr), 64'(19'h40000));
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 18'd3, 36'h0CAFEF00D);
    chk("tp_swap_wr", 64'(mem_addr), 64'(19'h00003));
    idle(3);

    // Four back-to-back strobes.
    for (int i = 0; i < 4; i++) step(1'b1, 10'(100 + 40 * i), 10'(20 + i), 1'b0, 1'b0, 18'd0, 36'd0);
    idle(4);

    // Randomized traffic with a protocol-following write requester.
    rq = 1'b0; ra = '0; rdat = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!rq && ($urandom_range(1, 0) == 1)) begin
        rq   = 1'b1;
        ra   = 18'($urandom);
        rdat = {4'($urandom), 32'($urandom)};
      end
      vf = ($urandom_range(2, 0) == 0);
      h  = ($urandom_range(7, 0) == 0) ? 10'($urandom_range(1023, 640)) : 10'($urandom_range(639, 0));
      v  = ($urandom_range(7, 0) == 0) ? 10'($urandom_range(1023, 480)) : 10'($urandom_range(479, 0));
      ff = ($urandom_range(39, 0) == 0);
      step(vf, h, v, ff, rq, ra, rdat);
      if (m_ack) begin
        if ($urandom_range(1, 0) == 1) begin
          rq = 1'b0;
        end else begin
          ra   = 18'($urandom);
          rdat = {4'($urandom), 32'($urandom)};
        end
      end
    end
    idle(6);
    chk("drain_done_q", 64'(done_q.size()), 64'(0));
    chk("drain_wd_q", 64'(wd_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
